lease_sample_reader: RTL and testbench

- Drain engine on the consumer side of the lease sampler buffer. It reads the four sample BRAMs (PC address, reuse interval, trace index, target tag) entry by entry, from index 0 to used-1.
- Each entry is serialized into a 32-bit valid/ready word stream toward the host comm path.
- On completion it pulses a clear request back to the sampler, which resets the sampler's buffer pointer and releases the core stall.

---
 rtl/lease_sample_reader_if.sv | 25 ++
 rtl/lease_sample_reader.sv | 203 ++++++++++++++++++++
 tb/tb_lease_sample_reader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lease_sample_reader_if.sv
// Buffer read port and host word stream of the lease sample reader.
interface lease_sample_reader_if #(
    parameter int unsigned BW_ADDR = 13
);
    logic [BW_ADDR-1:0] rd_addr_o;
    logic               rd_en_o;
    logic [31:0]        ref_address_i;
    logic [31:0]        ref_interval_i;
    logic [63:0]        ref_trace_i;
    logic [31:0]        ref_target_i;
    logic [31:0]        data_o;
    logic               valid_o;
    logic               ready_i;
    logic               last_o;

    modport master (
        output rd_addr_o, rd_en_o, data_o, valid_o, last_o,
        input  ref_address_i, ref_interval_i, ref_trace_i, ref_target_i, ready_i
    );

    modport slave (
        input  rd_addr_o, rd_en_o, data_o, valid_o, last_o,
        output ref_address_i, ref_interval_i, ref_trace_i, ref_target_i, ready_i
    );
endinterface

// File: rtl/lease_sample_reader.sv
// Drains the lease sampler BRAMs into a 32-bit valid/ready word stream, then pulses a buffer clear.
// Optional: define LEASE_SAMPLE_READER_CHECKSUM_EN to append an XOR checksum word to each drain.
module lease_sample_reader #(
    parameter int unsigned BW_ADDR      = 13,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clock_i,
    input  logic                  resetn_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [BW_ADDR:0]      used_i,
    output logic                  busy_o,
    output logic                  clear_o,
    output logic [BW_ADDR:0]      entries_o,
    lease_sample_reader_if.master bus
);
    localparam int unsigned   CW        = BW_ADDR + 1;
    localparam logic [CW-1:0] MAX_COUNT = CW'(1) << BW_ADDR;

    typedef enum logic [2:0] {
        ST_IDLE, ST_READ, ST_WAIT, ST_SEND, ST_EMPTY, ST_CSUM, ST_DONE
    } state_t;

    state_t             r_state;
    logic [BW_ADDR-1:0] r_idx;
    logic [BW_ADDR-1:0] r_rd_addr;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      r_entries;
    logic [1:0]         r_wait;
    logic [2:0]         r_word;
    logic [31:0]        r_intv;
    logic [31:0]        r_tgt;
    logic [63:0]        r_trace;
    logic [31:0]        r_data;
    logic               r_rd_en;
    logic               r_valid;
    logic               r_last;
    logic               r_busy;
    logic               r_clear;
`ifdef LEASE_SAMPLE_READER_CHECKSUM_EN
    logic [31:0]        r_csum;
`endif

    logic               w_more;
    logic [31:0]        w_next;

    assign w_more = ({1'b0, r_idx} + CW'(1)) < r_count;

    // Word that follows the one currently on data_o within an entry.
    always_comb begin
        w_next = r_intv;
        case (r_word)
            3'd1:    w_next = r_trace[31:0];
            3'd2:    w_next = r_trace[63:32];
            3'd3:    w_next = r_tgt;
            default: w_next = r_intv;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_rd_addr <= '0;
            r_count   <= '0;
            r_entries <= '0;
            r_wait    <= '0;
            r_word    <= '0;
            r_intv    <= '0;
            r_tgt     <= '0;
            r_trace   <= '0;
            r_data    <= '0;
            r_rd_en   <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_clear   <= 1'b0;
`ifdef LEASE_SAMPLE_READER_CHECKSUM_EN
            r_csum    <= '0;
`endif
        end else begin
            r_rd_en <= 1'b0;
            r_clear <= 1'b0;
            if (abort_i && r_busy) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    // DONE accepts a new start just like IDLE since busy_o is already low.
                    ST_IDLE, ST_DONE: begin
                        r_state <= ST_IDLE;
                        if (start_i && !abort_i) begin
                            r_entries <= '0;
                            r_busy    <= 1'b1;
`ifdef LEASE_SAMPLE_READER_CHECKSUM_EN
                            r_csum    <= '0;
`endif
                            if (used_i != '0) begin
                                r_count   <= (used_i > MAX_COUNT) ? MAX_COUNT : used_i;
                                r_idx     <= '0;
                                r_rd_addr <= '0;
                                r_rd_en   <= 1'b1;
                                r_state   <= ST_READ;
                            end else begin
`ifdef LEASE_SAMPLE_READER_CHECKSUM_EN
                                r_data  <= '0;
                                r_valid <= 1'b1;
                                r_last  <= 1'b1;
                                r_state <= ST_CSUM;
`else
                                r_state <= ST_EMPTY;
`endif
                            end
                        end
                    end
                    ST_READ: begin
                        r_wait  <= '0;
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (r_wait == 2'(READ_LATENCY - 1)) begin
                            r_data  <= bus.ref_address_i;
                            r_intv  <= bus.ref_interval_i;
                            r_trace <= bus.ref_trace_i;
                            r_tgt   <= bus.ref_target_i;
                            r_word  <= '0;
                            r_valid <= 1'b1;
                            r_last  <= 1'b0;
                            r_state <= ST_SEND;
                        end else begin
                            r_wait <= r_wait + 2'd1;
                        end
                    end
                    ST_SEND: begin
                        if (bus.ready_i) begin
`ifdef LEASE_SAMPLE_READER_CHECKSUM_EN
                            r_csum <= r_csum ^ r_data;
`endif
                            if (r_word == 3'd4) begin
                                r_entries <= r_entries + CW'(1);
                                r_valid   <= 1'b0;
                                r_last    <= 1'b0;
                                if (w_more) begin
                                    r_idx     <= r_idx + BW_ADDR'(1);
                                    r_rd_addr <= r_idx + BW_ADDR'(1);
                                    r_rd_en   <= 1'b1;
                                    r_state   <= ST_READ;
                                end else begin
`ifdef LEASE_SAMPLE_READER_CHECKSUM_EN
                                    r_data  <= r_csum ^ r_data;
                                    r_valid <= 1'b1;
                                    r_last  <= 1'b1;
                                    r_state <= ST_CSUM;
`else
                                    r_clear <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= ST_DONE;
`endif
                                end
                            end else begin
                                r_word <= r_word + 3'd1;
                                r_data <= w_next;
`ifdef LEASE_SAMPLE_READER_CHECKSUM_EN
                                r_last <= 1'b0;
`else
                                r_last <= (r_word == 3'd3) && !w_more;
`endif
                            end
                        end
                    end
`ifdef LEASE_SAMPLE_READER_CHECKSUM_EN
                    ST_CSUM: begin
                        if (bus.ready_i) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_clear <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end
                    end
`endif
                    ST_EMPTY: begin
                        r_clear <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.rd_addr_o = r_rd_addr;
    assign bus.rd_en_o   = r_rd_en;
    assign bus.data_o    = r_data;
    assign bus.valid_o   = r_valid;
    assign bus.last_o    = r_last;
    assign busy_o        = r_busy;
    assign clear_o       = r_clear;
    assign entries_o     = r_entries;
endmodule

// File: tb/tb_lease_sample_reader.sv
// Randomized bench for lease_sample_reader: BRAM model plus a word-list reference of each drain.
module tb_lease_sample_reader;
    localparam int unsigned BW    = 4;
    localparam int unsigned CW    = BW + 1;
    localparam int unsigned LAT   = 1;
    localparam int          DEPTH = 2 ** BW;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } word_t;

    logic          clk   = 1'b0;
    logic          rstn  = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] used  = '0;
    logic          busy;
    logic          clear;
    logic [CW-1:0] entries;

    lease_sample_reader_if #(.BW_ADDR(BW)) bus ();

    lease_sample_reader #(.BW_ADDR(BW), .READ_LATENCY(LAT)) dut (
        .clock_i  (clk),
        .resetn_i (rstn),
        .start_i  (start),
        .abort_i  (abort),
        .used_i   (used),
        .busy_o   (busy),
        .clear_o  (clear),
        .entries_o(entries),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] m_addr  [DEPTH];
    logic [31:0] m_intv  [DEPTH];
    logic [63:0] m_trace [DEPTH];
    logic [31:0] m_tgt   [DEPTH];

    // BRAM model: data appears LAT cycles after the strobe and is garbage otherwise.
    logic [BW-1:0] a1;
    logic          e1;
    wire  [BW-1:0] rd_a = (LAT == 1) ? bus.rd_addr_o : a1;
    wire           rd_e = (LAT == 1) ? bus.rd_en_o : e1;
    always @(posedge clk) begin
        a1 <= bus.rd_addr_o;
        e1 <= bus.rd_en_o;
        if (rd_e) begin
            bus.ref_address_i  <= m_addr[rd_a];
            bus.ref_interval_i <= m_intv[rd_a];
            bus.ref_trace_i    <= m_trace[rd_a];
            bus.ref_target_i   <= m_tgt[rd_a];
        end else begin
            bus.ref_address_i  <= $urandom;
            bus.ref_interval_i <= $urandom;
            bus.ref_trace_i    <= {$urandom, $urandom};
            bus.ref_target_i   <= $urandom;
        end
    end

    int    n_checks = 0;
    int    n_errors = 0;
    word_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) begin
            m_addr[i]  = $urandom;
            m_intv[i]  = $urandom;
            m_trace[i] = {$urandom, $urandom};
            m_tgt[i]   = $urandom;
        end
    endtask

    // Expected stream: five words per entry, last on the final word (or trailing XOR word).
    task automatic build_expected(input int n_used);
        int          cnt;
        logic [31:0] x;
        cnt = (n_used > DEPTH) ? DEPTH : n_used;
        exp_q.delete();
        for (int e = 0; e < cnt; e++) begin
            exp_q.push_back('{m_addr[e], 1'b0});
            exp_q.push_back('{m_intv[e], 1'b0});
            exp_q.push_back('{m_trace[e][31:0], 1'b0});
            exp_q.push_back('{m_trace[e][63:32], 1'b0});
            exp_q.push_back('{m_tgt[e], 1'b0});
        end
`ifdef LEASE_SAMPLE_READER_CHECKSUM_EN
        x = '0;
        foreach (exp_q[i]) x = x ^ exp_q[i].data;
        exp_q.push_back('{x, 1'b1});
`else
        x = '0;
        if (cnt > 0) exp_q[exp_q.size() - 1].last = 1'b1;
`endif
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            default: return ($urandom % 4) != 0;
        endcase
    endfunction

    // kill_kind: 0 none, 1 abort, 2 reset; applied while word kill_word is stalled.
    task automatic run_drain(input int n_used, input int mode, input int kill_kind,
                             input int kill_word, input bit poke);
        int          cnt, n_exp, budget;
        int          words, cyc, clears, last_cyc, clear_cyc, rd_seen;
        bit          stalled, done, kill_armed, killing, killed;
        logic [31:0] held;
        word_t       w;
        cnt   = (n_used > DEPTH) ? DEPTH : n_used;
        build_expected(n_used);
        n_exp = exp_q.size();
        budget = cnt * 40 + 40;
        words = 0; cyc = 0; clears = 0; last_cyc = -1; clear_cyc = -1; rd_seen = 0;
        stalled = 1'b0; done = 1'b0; killed = 1'b0; held = '0;
        kill_armed = (kill_kind != 0);
        @(posedge clk); #1;
        start = 1'b1;
        used  = CW'(n_used);
        @(posedge clk); #1;
        start = 1'b0;
        used  = CW'($urandom);
        while (!done && cyc < budget) begin
            killing = 1'b0;
            start   = poke && (cyc == 3);
            if (start) used = CW'($urandom_range(1, DEPTH));
            if (kill_armed && stalled && words == kill_word) begin
                killing    = 1'b1;
                kill_armed = 1'b0;
                if (kill_kind == 1) begin
                    abort       = 1'b1;
                    bus.ready_i = 1'b1;
                end else begin
                    rstn = 1'b0;
                end
            end else if (kill_armed && words == kill_word) begin
                bus.ready_i = 1'b0;
            end else begin
                bus.ready_i = pick_ready(mode, cyc);
            end
            @(negedge clk);
            if (cyc == 0) check("busy_after_start", 64'(busy), 64'(1));
            if (stalled) begin
                check("hold_valid", 64'(bus.valid_o), 64'(1));
                check("hold_data", 64'(bus.data_o), 64'(held));
            end
            if (!killing && bus.valid_o && bus.ready_i) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 64'(bus.data_o), 64'hDEAD_0000_0000_0000);
                end else begin
                    w = exp_q.pop_front();
                    check("word_data", 64'(bus.data_o), 64'(w.data));
                    check("word_last", 64'(bus.last_o), 64'(w.last));
                end
                words++;
                if (bus.last_o) last_cyc = cyc;
            end
            if (bus.rd_en_o) begin
                check("rd_addr", 64'(bus.rd_addr_o), 64'(rd_seen));
                rd_seen++;
            end
            if (clear) begin
                clears++;
                if (clear_cyc < 0) clear_cyc = cyc;
                check("busy_with_clear", 64'(busy), 64'(0));
            end
            stalled = bus.valid_o && !bus.ready_i;
            held    = bus.data_o;
            if (killing) begin
                @(posedge clk); #1;
                abort = 1'b0;
                rstn  = 1'b1;
                @(negedge clk);
                check("kill_valid", 64'(bus.valid_o), 64'(0));
                check("kill_rd_en", 64'(bus.rd_en_o), 64'(0));
                check("kill_busy", 64'(busy), 64'(0));
                check("kill_clear", 64'(clear), 64'(0));
                check("kill_entries", 64'(entries), (kill_kind == 1) ? 64'(words / 5) : 64'(0));
                if (kill_kind == 2) begin
                    check("rst_data", 64'(bus.data_o), 64'(0));
                    check("rst_last", 64'(bus.last_o), 64'(0));
                    check("rst_rd_addr", 64'(bus.rd_addr_o), 64'(0));
                end
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("no_clear_after_kill", 64'(clear), 64'(0));
                end
                done   = 1'b1;
                killed = 1'b1;
            end
            if (clear_cyc >= 0 && cyc >= clear_cyc + 2) done = 1'b1;
            cyc++;
            @(posedge clk); #1;
        end
        bus.ready_i = 1'b0;
        check("drain_finished", 64'(done), 64'(1));
        if (!killed) begin
            check("words_left", 64'(exp_q.size()), 64'(0));
            check("clear_pulses", 64'(clears), 64'(1));
            check("entries", 64'(entries), 64'(cnt));
            check("clear_timing", 64'(clear_cyc), (n_exp > 0) ? 64'(last_cyc + 1) : 64'(1));
            check("busy_end", 64'(busy), 64'(0));
        end
    endtask

    initial begin
        bus.ready_i = 1'b0;
        fill_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_clear", 64'(clear), 64'(0));
        check("rst_entries", 64'(entries), 64'(0));
        check("rst_valid", 64'(bus.valid_o), 64'(0));
        check("rst_last", 64'(bus.last_o), 64'(0));
        check("rst_data", 64'(bus.data_o), 64'(0));
        check("rst_rd_en", 64'(bus.rd_en_o), 64'(0));
        check("rst_rd_addr", 64'(bus.rd_addr_o), 64'(0));
        @(posedge clk); #1;
        rstn = 1'b1;

        // Single entry with the documented sample values.
        m_addr[0]  = 32'h0040_0010;
        m_intv[0]  = 32'h0000_0007;
        m_trace[0] = 64'h0000_0002_0000_0005;
        m_tgt[0]   = 32'h000A_BCDE;
        run_drain(1, 0, 0, 0, 1'b0);

        fill_mem();
        run_drain(3, 1, 0, 0, 1'b0);

        fill_mem();
        m_intv[0] = 32'hFFFF_FFF6;
        run_drain(2, 2, 0, 0, 1'b0);

        run_drain(0, 0, 0, 0, 1'b0);

        // Abort and start together from IDLE: nothing may start.
        @(posedge clk); #1;
        abort = 1'b1; start = 1'b1; used = CW'(3);
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_start_busy", 64'(busy), 64'(0));
        check("abort_start_rd_en", 64'(bus.rd_en_o), 64'(0));
        @(negedge clk);
        check("abort_start_valid", 64'(bus.valid_o), 64'(0));

        fill_mem();
        run_drain(4, 0, 1, 7, 1'b0);
        fill_mem();
        run_drain(2, 0, 0, 0, 1'b0);

        fill_mem();
        run_drain(5, 2, 2, 11, 1'b0);
        fill_mem();
        run_drain(3, 0, 0, 0, 1'b0);

        fill_mem();
        run_drain(25, 2, 0, 0, 1'b0);
        run_drain(DEPTH, 0, 0, 0, 1'b0);

        fill_mem();
        run_drain(3, 0, 0, 0, 1'b1);

        for (int k = 0; k < 4; k++) begin
            fill_mem();
            run_drain($urandom_range(1, 20), 2, 0, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
